// File: rtl/imem_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
//   Shared definitions for the instruction fetch controller and its skid FIFO:
//   controller state encoding, default halt instruction, FIFO depth and the
//   width of the FIFO occupancy counter, plus a saturating counter helper.
// ---------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam int FIFO_DEPTH = 2;
  // Occupancy counter must be able to represent FIFO_DEPTH itself.
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO (FIFO_DEPTH entries) that holds fetched
//   {instruction, pc} pairs between the memory and decode.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset, empties the FIFO
//   push       in   enqueue wdata (ignored when full without a pop)
//   pop        in   drop the head (ignored when empty)
//   flush      in   empty the FIFO; overrides push and pop in that cycle
//   wdata      in   entry to enqueue
//   count      out  number of valid entries
//   head_valid out  FIFO is non-empty
//   head       out  oldest entry, forced to zero while empty
// ---------------------------------------------------------------------------
module fetch_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 38
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      wdata,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  head_valid,
  output logic [WIDTH-1:0]      head
);

  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [FIFO_PTR_W-1:0] LAST_PTR = FIFO_PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [FIFO_PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [FIFO_CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0]      entries [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO may still accept.
  assign do_pop  = pop && (count_reg != '0) && !flush;
  assign do_push = push && !flush && ((count_reg < FULL_CNT) || do_pop);

  // One storage register per slot; only the slot under wr_ptr is written.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (do_push && (wr_ptr_reg == FIFO_PTR_W'(gi))) begin
        entry_reg <= wdata;
      end
    end

    assign entries[gi] = entry_reg;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_next = count_reg + FIFO_CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_next = count_reg - FIFO_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  // Zeroed when empty so stale popped data never appears on the outputs.
  assign head       = head_valid ? entries[rd_ptr_reg] : '0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction fetch sequencer for an asynchronous-read instruction memory.
//   Holds the PC, drives the memory address, pushes each returned word with
//   its PC into a 2-entry skid FIFO and hands the head to decode with a
//   valid/ready handshake. Supports start, redirect-with-flush and a halt
//   instruction that stops fetching once it has been enqueued.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   start          in   pulse, IDLE -> RUN
//   imem_addr      out  word address to instruction memory (= PC register)
//   imem_data      in   instruction memory read data, same cycle
//   redirect_valid in   branch/jump taken: flush FIFO and reload PC
//   redirect_pc    in   new PC when redirect_valid is high
//   if_valid       out  FIFO head valid
//   if_instr       out  FIFO head instruction
//   if_pc          out  PC of the FIFO head
//   if_ready       in   decode accepts the head this cycle
//   halted         out  controller is in HALT
//   fetch_cnt      out  words enqueued since reset, saturating
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W    = 6,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  output logic              halted,
  output logic [15:0]       fetch_cnt
);

  localparam int                    ENTRY_W  = DATA_W + ADDR_W;
  localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  fetch_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]     pc_reg, pc_next;
  logic [15:0]           fetch_cnt_reg, fetch_cnt_next;

  logic                  pop;
  logic                  push;
  logic                  room;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  head_valid;
  logic [ENTRY_W-1:0]    head;

  assign pop  = head_valid && if_ready;
  // Space exists if not full, or if the head leaves in this same cycle.
  assign room = (fifo_count < FULL_CNT) || pop;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    fetch_cnt_next = fetch_cnt_reg;
    push           = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over everything: the FIFO is flushed and no word is
      // fetched this cycle; the new stream starts on the next edge.
      pc_next = redirect_pc;
      unique case (state_reg)
        ST_HALT: state_next = ST_RUN;
        ST_IDLE: if (start) state_next = ST_RUN;
        default: state_next = state_reg;
      endcase
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (room) begin
            push           = 1'b1;
            fetch_cnt_next = sat_inc16(fetch_cnt_reg);
            // The halt word is enqueued but the PC stays parked on it.
            if (imem_data == HALT_WORD) begin
              state_next = ST_HALT;
            end else begin
              pc_next = pc_reg + ADDR_W'(1);
            end
          end
        end
        ST_HALT: begin
          state_next = ST_HALT;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_PC;
      fetch_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .wdata      ({imem_data, pc_reg}),
    .count      (fifo_count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign imem_addr = pc_reg;
  assign if_valid  = head_valid;
  assign if_instr  = head[ENTRY_W-1:ADDR_W];
  assign if_pc     = head[ADDR_W-1:0];
  assign halted    = (state_reg == ST_HALT);
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        if_ready = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_pc;
  logic        halted;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  // Instruction memory (asynchronous read).
  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  // Reference model: queue of delivered-but-not-yet-taken words, the PC,
  // a mode (0 idle, 1 fetching, 2 halted) and the fetch count.
  logic [37:0] m_q[$];
  int          m_pc;
  int          m_mode;
  int          m_cnt;
  int          dlv[$];   // PCs handed to decode, in order

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDR_W    (6),
    .DATA_W    (32),
    .RESET_PC  (6'd0),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int k = 0; k < 64; k++) mem[k] = 32'h100 + k;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 0;
    m_mode = 0;
    m_cnt = 0;
  endtask

  task automatic check_model();
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("if_valid", 64'(if_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("if_instr", 64'(if_instr), 64'(m_q[0][37:6]));
      chk("if_pc", 64'(if_pc), 64'(m_q[0][5:0]));
    end
    chk("halted", 64'(halted), 64'(m_mode == 2));
    chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
  endtask

  // Advance the model over one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [31:0] w;
    bit take;
    take = (m_q.size() != 0) && if_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = int'(redirect_pc);
      if (m_mode == 2) m_mode = 1;
      else if (m_mode == 0 && start) m_mode = 1;
    end else begin
      if (take) begin
        $display("xfer pc=%0d instr=%h", m_q[0][5:0], m_q[0][37:6]);
        dlv.push_back(int'(m_q[0][5:0]));
        void'(m_q.pop_front());
      end
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 1 && m_q.size() < 2) begin
        w = mem[m_pc];
        m_q.push_back({w, 6'(m_pc)});
        if (m_cnt < 65535) m_cnt++;
        if (w == 32'hFFFF_FFFF) m_mode = 2;
        else m_pc = (m_pc + 1) % 64;
      end
    end
  endtask

  task automatic step(input bit st, input bit rv, input logic [5:0] rpc, input bit rdy);
    start = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    if_ready = rdy;
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; redirect_valid = 0; if_ready = 0; redirect_pc = '0;
    reset = 1'b1;
    #1;
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    model_reset();
    dlv.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int guard;
    fill_mem();
    model_reset();

    // 1: start, streaming at one word per cycle
    do_reset();
    step(1, 0, 0, 1);
    chk("t1_valid_after_start", 64'(if_valid), 64'd0);
    step(0, 0, 0, 1);
    chk("t1_first_valid", 64'(if_valid), 64'd1);
    chk("t1_first_pc", 64'(if_pc), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) chk("t1_seq", 64'(dlv[i]), 64'(i));

    // 2: backpressure
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("t2_addr_hold", 64'(imem_addr), 64'd2);
    chk("t2_head_pc", 64'(if_pc), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) chk("t2_seq", 64'(dlv[i]), 64'(i));

    // 3: redirect while FIFO holds 5,6
    do_reset();
    step(1, 0, 0, 1);
    guard = 0;
    while ((m_q.size() == 0 || m_q[0][5:0] != 6'd5) && guard < 20) begin
      step(0, 0, 0, 1);
      guard++;
    end
    chk("t3_reach5", 64'(guard < 20), 64'd1);
    step(0, 0, 0, 0);
    base = dlv.size();
    step(0, 1, 6'd40, 1);
    chk("t3_flushed", 64'(if_valid), 64'd0);
    step(0, 0, 0, 1);
    chk("t3_new_valid", 64'(if_valid), 64'd1);
    chk("t3_new_pc", 64'(if_pc), 64'd40);
    step(0, 0, 0, 1);
    chk("t3_next_dlv", 64'(dlv[base]), 64'd40);

    // 4: halt word at address 3, then redirect out of HALT
    do_reset();
    mem[3] = 32'hFFFF_FFFF;
    step(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("t4_halted", 64'(halted), 64'd1);
    chk("t4_addr", 64'(imem_addr), 64'd3);
    chk("t4_cnt", 64'(fetch_cnt), 64'd4);
    chk("t4_dlv_n", 64'(dlv.size()), 64'd4);
    base = dlv.size();
    step(0, 1, 6'd10, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("t4_resume_halted", 64'(halted), 64'd0);
    chk("t4_resume_pc", 64'(dlv[base]), 64'd10);
    mem[3] = 32'h103;

    // 5: wrap of the PC
    base = dlv.size();
    step(0, 1, 6'd62, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("t5_wrap0", 64'(dlv[base]), 64'd62);
    chk("t5_wrap1", 64'(dlv[base+1]), 64'd63);
    chk("t5_wrap2", 64'(dlv[base+2]), 64'd0);
    chk("t5_wrap3", 64'(dlv[base+3]), 64'd1);

    // 6: asynchronous reset with a full FIFO
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("t6_full_valid", 64'(if_valid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 64'(if_valid), 64'd0);
    chk("t6_async_cnt", 64'(fetch_cnt), 64'd0);
    chk("t6_async_addr", 64'(imem_addr), 64'd0);
    chk("t6_async_halted", 64'(halted), 64'd0);
    do_reset();

    // Random phase against the reference model
    for (int k = 0; k < 64; k++)
      mem[k] = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom;
    step(1, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      bit rv;
      bit st;
      rv = ($urandom_range(0, 15) == 0);
      st = !rv && ($urandom_range(0, 7) == 0);
      step(st, rv, 6'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
